// File: rtl/pmem_pkg.sv
// Shared constants and types for the pmem line responder and its line store.
// Pure declarations: no latency or backpressure of its own.
package pmem_pkg;

  localparam int          LINE_W    = 256;
  localparam int          OFFSET_W  = 5;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_store.sv
// Line array: synchronous write, combinational read, contents survive reset.
// Write lands at the clock edge; read data follows raddr within the cycle; never stalls.
module pmem_line_store
  import pmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pmem_line_responder.sv
// Backing-memory responder for the 256-bit pmem line bus: held request in, one-cycle pmem_resp LATENCY cycles later.
// One transaction at a time (busy through DONE); define PMEM_RANDOM_LATENCY_EN to add 0..3 cycles of LFSR jitter.
module pmem_line_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6,
  parameter int LINE_W     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              busy,
  output logic              proto_err
);
  import pmem_pkg::*;

  localparam int               TAG_W    = 32 - OFFSET_W;
  localparam int               CNT_W    = 9;
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(LATENCY - 1);

  pmem_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_load;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [TAG_W-1:0]      tag_q;
  logic [1:0]            req_q;
  logic                  wr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rdata_q;
  logic [LINE_W-1:0]     store_rdata;
  logic                  resp_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  store_we;
  logic                  req_chg;
  logic                  unused_addr_bits;

`ifdef PMEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign cnt_load = CNT_BASE + CNT_W'(lfsr_q[1:0]);
`else
  assign cnt_load = CNT_BASE;
`endif

  assign unused_addr_bits = ^pmem_address[OFFSET_W-1:0];

  // The requester must hold line address and request bits steady while we wait.
  assign req_chg  = ({pmem_write, pmem_read} != req_q) ||
                    (pmem_address[31:OFFSET_W] != tag_q);
  assign raddr    = (state_q == IDLE) ? pmem_address[OFFSET_W +: DEPTH_LOG2] : idx_q;
  assign store_we = rst_n && (state_q == RESP) && wr_q;

  pmem_line_store #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            idx_q   <= pmem_address[OFFSET_W +: DEPTH_LOG2];
            tag_q   <= pmem_address[31:OFFSET_W];
            req_q   <= {pmem_write, pmem_read};
            wr_q    <= pmem_write;
            wdata_q <= pmem_wdata;
            cnt_q   <= cnt_load;
            busy_q  <= 1'b1;
            if (pmem_read && pmem_write) begin
              err_q <= 1'b1;
            end
            if (cnt_load == '0) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= pmem_write ? '0 : store_rdata;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (req_chg) begin
            err_q <= 1'b1;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            rdata_q <= wr_q ? '0 : store_rdata;
          end
        end
        RESP: begin
          state_q <= DONE;
        end
        DONE: begin
          // Requester may still be holding its request this cycle.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign busy       = busy_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: vector table of line transactions plus protocol corner sequences.
// Also covers jittered latency when built with PMEM_RANDOM_LATENCY_EN.
module tb_pmem_line_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         proto_err;

  always #5 clk = ~clk;

  pmem_line_responder #(
    .LATENCY    (LAT),
    .DEPTH_LOG2 (6),
    .LINE_W     (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
    bit           exp_err;
  } vec_t;

  vec_t         vecs[10];
  int           checks = 0;
  int           errors = 0;
  int           lat;
  logic [255:0] seen;
  logic [255:0] dead, line_a, line_b, line_c, line_p, line_80, line_a0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int l);
`ifdef PMEM_RANDOM_LATENCY_EN
    chk(name, 256'(l >= LAT && l <= LAT + 3), 256'(1));
`else
    chk(name, 256'(l), 256'(LAT));
`endif
  endtask

  task automatic drop_req();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // Drives one request from a negedge; returns just before the next request can be accepted.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wd, input bit chg, input logic [31:0] addr2,
                         input int hold, output int l, output logic [255:0] s);
    l = 0;
    s = '0;
    @(negedge clk);
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = addr;
    pmem_wdata   = wd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("busy_in_wait", 256'(busy), 256'(1));
        if (chg) pmem_address = addr2;
      end
      if (pmem_resp) begin
        l = k;
        s = pmem_rdata;
        break;
      end
    end
    chk("resp_seen", 256'(l != 0), 256'(1));
    if (hold == 0) drop_req();
    @(negedge clk);
    chk("done_resp", 256'(pmem_resp), 256'(0));
    chk("done_rdata", pmem_rdata, '0);
    chk("done_busy", 256'(busy), 256'(1));
    if (hold != 0) begin
      @(negedge clk);
      drop_req();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drop_req();
    @(negedge clk);
    chk({tag, "_resp"}, 256'(pmem_resp), 256'(0));
    chk({tag, "_rdata"}, pmem_rdata, '0);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_err"}, 256'(proto_err), 256'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    dead    = {8{32'hDEADBEEF}};
    line_a  = {8{32'h0A0A_1111}};
    line_b  = {8{32'hB0B0_2222}};
    line_c  = {8{32'hC0C0_3333}};
    line_p  = {8{32'h5050_4444}};
    line_80 = {8{32'h8080_5555}};
    line_a0 = {8{32'hA0A0_6666}};

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, dead,    '0,      1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, '0,      dead,    1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, line_a,  '0,      1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_083F, '0,      line_a,  1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0080, line_80, '0,      1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_00A0, line_a0, '0,      1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_00C0, line_p,  '0,      1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_00C0, '0,      line_p,  1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'hFFFF_1040, '0,      dead,    1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h0000_00BF, '0,      line_a0, 1'b0};

    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    chk("reset_resp", 256'(pmem_resp), 256'(0));
    chk("reset_rdata", pmem_rdata, '0);
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_err", 256'(proto_err), 256'(0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0, '0, 0, lat, seen);
      chk_lat($sformatf("vec%0d_latency", i), lat);
      chk($sformatf("vec%0d_rdata", i), seen, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 256'(proto_err), 256'(vecs[i].exp_err));
    end

    // Read held through the cycle after resp must not be serviced twice.
    run_txn(1'b0, 1'b1, 32'h40, '0, 1'b0, '0, 2, lat, seen);
    chk("held_rdata", seen, dead);
    @(negedge clk);
    chk("held_idle_busy", 256'(busy), 256'(0));
    begin
      bit extra = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (pmem_resp) extra = 1'b1;
        @(negedge clk);
      end
      chk("held_no_second_resp", 256'(extra), 256'(0));
    end
    run_txn(1'b0, 1'b1, 32'h20, '0, 1'b0, '0, 0, lat, seen);
    chk_lat("held_next_latency", lat);
    chk("held_next_rdata", seen, line_a);

    run_txn(1'b1, 1'b1, 32'h60, line_b, 1'b0, '0, 0, lat, seen);
    chk("both_rdata", seen, '0);
    chk("both_err", 256'(proto_err), 256'(1));
    run_txn(1'b0, 1'b1, 32'h60, '0, 1'b0, '0, 0, lat, seen);
    chk("both_readback", seen, line_b);

    do_reset("rst1");

    run_txn(1'b0, 1'b1, 32'h80, '0, 1'b1, 32'hA0, 0, lat, seen);
    chk_lat("addrchg_latency", lat);
    chk("addrchg_rdata", seen, line_80);
    chk("addrchg_err", 256'(proto_err), 256'(1));

    do_reset("rst2");

    // Reset lands in WAIT of a write; the old line must survive.
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 32'hC0;
    pmem_wdata   = line_c;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_resp", 256'(pmem_resp), 256'(0));
    chk("midrst_busy", 256'(busy), 256'(0));
    rst_n = 1'b1;
    drop_req();
    begin
      bit stray = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (pmem_resp) stray = 1'b1;
      end
      chk("midrst_no_resp", 256'(stray), 256'(0));
    end
    run_txn(1'b0, 1'b1, 32'hC0, '0, 1'b0, '0, 0, lat, seen);
    chk("midrst_readback", seen, line_p);
    chk("midrst_err", 256'(proto_err), 256'(0));

`ifdef PMEM_RANDOM_LATENCY_EN
    begin
      int min_l = 1000;
      int max_l = 0;
      logic [31:0]  ra[3];
      logic [255:0] rx[3];
      ra[0] = 32'h40; rx[0] = dead;
      ra[1] = 32'h20; rx[1] = line_a;
      ra[2] = 32'hA0; rx[2] = line_a0;
      for (int i = 0; i < 50; i++) begin
        run_txn(1'b0, 1'b1, ra[i % 3], '0, 1'b0, '0, 0, lat, seen);
        chk($sformatf("rand%0d_latency", i), 256'(lat >= LAT && lat <= LAT + 3), 256'(1));
        chk($sformatf("rand%0d_rdata", i), seen, rx[i % 3]);
        if (lat < min_l) min_l = lat;
        if (lat > max_l) max_l = lat;
      end
      chk("rand_distinct_latencies", 256'(max_l != min_l), 256'(1));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
